stage3: RTL and testbench
=========================

# stage3

Execute stage of the five-stage SCU pipeline: the consumer side of the ID/EX buffer that stage2 drives. Takes decoded operands and control bits, performs the ALU operation, keeps the Z/N condition flags, and resolves BRZ/BRN/J. Results and control bits are captured into an internal EX/MEM register for stage4. A taken branch or jump drives a registered PC redirect and flush.

## Interface
Parameters:
- WIDTH, 32, datapath width.
- RW, 6, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  ID/EX slot holds a real instruction.
- in_imm  in  WIDTH  sign-extended immediate.
- in_rd  in  RW  destination register index.
- in_rd1  in  WIDTH  operand A (xs).
- in_rd2  in  WIDTH  operand B (xt) / store data.
- in_PC  in  WIDTH  PC value from decode (PC+imm when SVPC).
- in_brz, in_brn, in_j  in  1 each  branch/jump controls.
- in_regw, in_wai, in_memw, in_memr, in_alusrc  in  1 each  write-back, write-PC-value, store, load, and B-is-immediate controls.
- in_aluop  in  3  ALU operation.
- mem_stall  in  1  stage4 cannot accept; hold all state.
- out_valid  out  1  EX/MEM slot valid.
- out_alu  out  WIDTH  result / memory address.
- out_rd2  out  WIDTH  store data.
- out_rd  out  RW  destination index.
- out_regw, out_memw, out_memr  out  1 each  forwarded controls, forced 0 when out_valid=0.
- out_flush  out  1  one-cycle pulse: taken branch/jump resolved last edge.
- out_target  out  WIDTH  redirect PC, valid with out_flush.
- out_z, out_n  out  1 each  current flag register.

## Operation
- Operand B is in_imm when in_alusrc=1, otherwise in_rd2.
- aluop encoding:
  - 000 ADD A+B; 001 SUB A−B; 010 NEG 0−A; 011 PASSA A.
  - 100 PASSB B; 101 AND; 110 OR; 111 XOR.
  - Arithmetic is modulo 2^WIDTH; no carry or overflow is kept.
- When in_wai=1, the result is in_PC instead of the ALU output.
- Flags:
  - Z = (result==0) and N = result[WIDTH-1].
  - Flags are written only when the instruction is accepted, in_regw=1, in_memr=0 and in_wai=0.
  - Branches read the flag register as it stood before the edge.
- Branch resolution for an accepted instruction:
  - taken = in_j | (in_brz & Z) | (in_brn & N).
  - target = in_rd1.
  - Branches and jumps enter EX/MEM with regw, memw and memr all 0.
- Accepted means in_valid & ~mem_stall & ~squash.
- squash is high for exactly the cycle after out_flush is set. It drops the one wrong-path instruction already in ID/EX. Upstream clears IF/ID and ID/EX on out_flush.
- States, held in the squash bit: RUN, then SQUASH (one cycle after a taken branch), then RUN.
  - A branch arriving during SQUASH is discarded, so no double flush occurs.

## Timing
- Latency is one cycle: inputs sampled at edge k appear on the out_* registers after edge k.
- out_flush and out_target are registered at the same edge as the branch's EX/MEM entry. out_flush is high for exactly one cycle.
- mem_stall=1:
  - EX/MEM, the flags and the squash bit all hold.
  - out_flush deasserts, so it never stretches.
  - Inputs are ignored; upstream must hold ID/EX.
- Not accepted (and no stall): out_valid=0 and all out_* control bits are 0; data fields are don't-care.
- Reset (rst_n=0 at an edge, including mid-flush or mid-stall):
  - out_valid, out_regw, out_memw, out_memr, out_flush, out_z, out_n and squash all go to 0.
  - out_alu, out_rd2, out_target and out_rd go to 0.
  - Reset takes priority over mem_stall.

## Structure
- Shared package stage_pkg holds:
  - ALUOP_ADD … ALUOP_XOR localparams.
  - The WIDTH/RW defaults.
  - A typedef for the ID/EX control bundle, reused by stage2 and stage4.
- One combinational sub-module, alu (a, b, op → result), instantiated once.
- Flag logic, branch resolution, squash and the EX/MEM register live in stage3.

## Test plan
- Reset check: hold rst_n=0 during an active flush, then release. All outputs must be 0 and squash clear. The first valid ADD must be accepted.
- ALU coverage: rd1=5, rd2=7 across all eight aluops with alusrc=0. Then alusrc=1, imm=−1, ADD gives 4. One cycle later, out_alu shows 12, −2, −5, 5, 7, 5, 7, 2 respectively.
- Flags and BRZ: SUB 3−3 sets Z=1, N=0. The following BRZ with rd1=0x40 gives out_flush=1 and out_target=0x40. The next valid instruction is squashed (out_valid=0).
- BRN not taken: after ADD 1+1 (N=0), BRN gives no flush and an out_valid=1 slot with regw/memw/memr all 0. A load (memr=1) with a result of 0 leaves Z unchanged.
- Stall: assert mem_stall for 3 cycles with a taken J in ID/EX. EX/MEM holds its value and the flush fires once, after the stall ends. out_flush is never high during the stall.
- WAI: in_wai=1, in_PC=0x100, aluop=SUB gives out_alu=0x100 with the flags unchanged.

Source files
------------

// File: rtl/stage_pkg.sv
// ============================================================================
// Module      : stage_pkg
// Description : Shared types and constants for the SCU pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_RW    = 6;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_NEG   = 3'b010;
    localparam logic [2:0] ALUOP_PASSA = 3'b011;
    localparam logic [2:0] ALUOP_PASSB = 3'b100;
    localparam logic [2:0] ALUOP_AND   = 3'b101;
    localparam logic [2:0] ALUOP_OR    = 3'b110;
    localparam logic [2:0] ALUOP_XOR   = 3'b111;

    // ID/EX control bundle shared by the decode, execute and memory stages
    typedef struct packed {
        logic       brz;
        logic       brn;
        logic       j;
        logic       regw;
        logic       wai;
        logic       memw;
        logic       memr;
        logic       alusrc;
        logic [2:0] aluop;
    } id_ex_ctrl_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } squash_state_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational eight-operation ALU, arithmetic modulo 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALUOP_ADD:   result = a + b;
            ALUOP_SUB:   result = a - b;
            ALUOP_NEG:   result = '0 - a;
            ALUOP_PASSA: result = a;
            ALUOP_PASSB: result = b;
            ALUOP_AND:   result = a & b;
            ALUOP_OR:    result = a | b;
            ALUOP_XOR:   result = a ^ b;
            default:     result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/stage3.sv
// ============================================================================
// Module      : stage3
// Description : Execute stage - ALU, Z/N flags, branch resolution, EX/MEM reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage3
    import stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RW    = DEF_RW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RW-1:0]    in_rd,
    input  logic [WIDTH-1:0] in_rd1,
    input  logic [WIDTH-1:0] in_rd2,
    input  logic [WIDTH-1:0] in_PC,
    input  logic             in_brz,
    input  logic             in_brn,
    input  logic             in_j,
    input  logic             in_regw,
    input  logic             in_wai,
    input  logic             in_memw,
    input  logic             in_memr,
    input  logic             in_alusrc,
    input  logic [2:0]       in_aluop,
    input  logic             mem_stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_alu,
    output logic [WIDTH-1:0] out_rd2,
    output logic [RW-1:0]    out_rd,
    output logic             out_regw,
    output logic             out_memw,
    output logic             out_memr,
    output logic             out_flush,
    output logic [WIDTH-1:0] out_target,
    output logic             out_z,
    output logic             out_n
);

    id_ex_ctrl_t      w_ctrl;
    squash_state_t    r_state;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_branch;
    logic             w_taken;
    logic             w_flag_we;

    assign w_ctrl = '{brz: in_brz, brn: in_brn, j: in_j, regw: in_regw,
                      wai: in_wai, memw: in_memw, memr: in_memr,
                      alusrc: in_alusrc, aluop: in_aluop};

    assign w_b = w_ctrl.alusrc ? in_imm : in_rd2;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (in_rd1),
        .b      (w_b),
        .op     (w_ctrl.aluop),
        .result (w_alu)
    );

    assign w_result  = w_ctrl.wai ? in_PC : w_alu;
    // The wrong-path slot behind a taken branch is dropped while in SQUASH
    assign w_accept  = in_valid & ~mem_stall & (r_state == RUN);
    assign w_branch  = w_ctrl.brz | w_ctrl.brn | w_ctrl.j;
    assign w_taken   = w_accept & (w_ctrl.j | (w_ctrl.brz & out_z) | (w_ctrl.brn & out_n));
    assign w_flag_we = w_accept & w_ctrl.regw & ~w_ctrl.memr & ~w_ctrl.wai;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            out_valid  <= 1'b0;
            out_alu    <= '0;
            out_rd2    <= '0;
            out_rd     <= '0;
            out_regw   <= 1'b0;
            out_memw   <= 1'b0;
            out_memr   <= 1'b0;
            out_flush  <= 1'b0;
            out_target <= '0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
        end else if (mem_stall) begin
            out_flush  <= 1'b0;
        end else begin
            out_valid  <= w_accept;
            out_alu    <= w_result;
            out_rd2    <= in_rd2;
            out_rd     <= in_rd;
            out_regw   <= w_accept & w_ctrl.regw & ~w_branch;
            out_memw   <= w_accept & w_ctrl.memw & ~w_branch;
            out_memr   <= w_accept & w_ctrl.memr & ~w_branch;
            out_flush  <= w_taken;
            if (w_taken) begin
                out_target <= in_rd1;
            end
            if (w_flag_we) begin
                out_z <= (w_result == '0);
                out_n <= w_result[WIDTH-1];
            end
            r_state    <= w_taken ? SQUASH : RUN;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage3.sv
// ============================================================================
// Module      : tb_stage3
// Description : Directed self-checking bench for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage3;

    localparam int WIDTH = 32;
    localparam int RW    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_imm;
    logic [RW-1:0]    in_rd;
    logic [WIDTH-1:0] in_rd1;
    logic [WIDTH-1:0] in_rd2;
    logic [WIDTH-1:0] in_PC;
    logic             in_brz, in_brn, in_j;
    logic             in_regw, in_wai, in_memw, in_memr, in_alusrc;
    logic [2:0]       in_aluop;
    logic             mem_stall;
    logic             out_valid;
    logic [WIDTH-1:0] out_alu;
    logic [WIDTH-1:0] out_rd2;
    logic [RW-1:0]    out_rd;
    logic             out_regw, out_memw, out_memr;
    logic             out_flush;
    logic [WIDTH-1:0] out_target;
    logic             out_z, out_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage3 #(.WIDTH(WIDTH), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .in_rd1     (in_rd1),
        .in_rd2     (in_rd2),
        .in_PC      (in_PC),
        .in_brz     (in_brz),
        .in_brn     (in_brn),
        .in_j       (in_j),
        .in_regw    (in_regw),
        .in_wai     (in_wai),
        .in_memw    (in_memw),
        .in_memr    (in_memr),
        .in_alusrc  (in_alusrc),
        .in_aluop   (in_aluop),
        .mem_stall  (mem_stall),
        .out_valid  (out_valid),
        .out_alu    (out_alu),
        .out_rd2    (out_rd2),
        .out_rd     (out_rd),
        .out_regw   (out_regw),
        .out_memw   (out_memw),
        .out_memr   (out_memr),
        .out_flush  (out_flush),
        .out_target (out_target),
        .out_z      (out_z),
        .out_n      (out_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_imm = '0; in_rd = '0; in_rd1 = '0; in_rd2 = '0; in_PC = '0;
        in_brz = 0; in_brn = 0; in_j = 0; in_regw = 0; in_wai = 0;
        in_memw = 0; in_memr = 0; in_alusrc = 0; in_aluop = 3'b000;
    endtask

    task automatic drive_alu(input logic [2:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
        idle();
        in_valid = 1; in_regw = 1; in_aluop = op; in_rd1 = a; in_rd2 = b; in_rd = 6'd3;
    endtask

    task automatic test_reset();
        rst_n = 0; mem_stall = 0; idle();
        step();
        rst_n = 1;
        idle(); in_valid = 1; in_j = 1; in_rd1 = 32'h55;
        step();
        n_checks++;
        if (out_flush !== 1'b1) begin
            n_fail++; $display("FAIL reset_preflush: out_flush=%b expected 1", out_flush);
        end
        rst_n = 0; mem_stall = 1;
        step();
        rst_n = 1; mem_stall = 0;
        n_checks++;
        if ({out_valid, out_regw, out_memw, out_memr, out_flush, out_z, out_n} !== 7'b0 ||
            out_alu !== '0 || out_rd2 !== '0 || out_target !== '0 || out_rd !== '0) begin
            n_fail++;
            $display("FAIL reset_state: v=%b rw=%b mw=%b mr=%b fl=%b z=%b n=%b alu=%h rd2=%h tgt=%h rd=%h expected all 0",
                     out_valid, out_regw, out_memw, out_memr, out_flush, out_z, out_n,
                     out_alu, out_rd2, out_target, out_rd);
        end
        drive_alu(3'b000, 32'd2, 32'd3);
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_alu !== 32'd5 || out_regw !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_add: valid=%b alu=%0d regw=%b expected 1/5/1", out_valid, out_alu, out_regw);
        end
    endtask

    task automatic test_alu();
        logic [WIDTH-1:0] exp_tab [8];
        exp_tab = '{32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 32'd5, 32'd7, 32'd5, 32'd7, 32'd2};
        for (int i = 0; i < 8; i++) begin
            drive_alu(3'(i), 32'd5, 32'd7);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_alu !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL alu_op%0d: valid=%b alu=%h expected 1/%h", i, out_valid, out_alu, exp_tab[i]);
            end
        end
        drive_alu(3'b000, 32'd5, 32'd7);
        in_alusrc = 1; in_imm = 32'hFFFF_FFFF;
        step();
        n_checks++;
        if (out_alu !== 32'd4) begin
            n_fail++; $display("FAIL alu_imm: alu=%h expected 4", out_alu);
        end
        idle(); in_regw = 1; in_memw = 1; in_memr = 1;
        step();
        n_checks++;
        if ({out_valid, out_regw, out_memw, out_memr} !== 4'b0) begin
            n_fail++;
            $display("FAIL invalid_slot: v/rw/mw/mr=%b%b%b%b expected 0000", out_valid, out_regw, out_memw, out_memr);
        end
    endtask

    task automatic test_flags_brz();
        drive_alu(3'b001, 32'd3, 32'd3);
        step();
        n_checks++;
        if (out_z !== 1'b1 || out_n !== 1'b0) begin
            n_fail++; $display("FAIL sub_flags: z=%b n=%b expected 1/0", out_z, out_n);
        end
        idle(); in_valid = 1; in_brz = 1; in_rd1 = 32'h40;
        step();
        n_checks++;
        if (out_flush !== 1'b1 || out_target !== 32'h40 || out_valid !== 1'b1 ||
            {out_regw, out_memw, out_memr} !== 3'b0) begin
            n_fail++;
            $display("FAIL brz_taken: flush=%b target=%h valid=%b ctl=%b%b%b expected 1/40/1/000",
                     out_flush, out_target, out_valid, out_regw, out_memw, out_memr);
        end
        drive_alu(3'b000, 32'd1, 32'd1);
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_flush !== 1'b0 || out_regw !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_slot: valid=%b flush=%b regw=%b expected 0/0/0", out_valid, out_flush, out_regw);
        end
        idle();
    endtask

    task automatic test_brn_not_taken();
        drive_alu(3'b000, 32'd1, 32'd1);
        step();
        idle(); in_valid = 1; in_brn = 1; in_regw = 1; in_rd1 = 32'h80;
        step();
        n_checks++;
        if (out_flush !== 1'b0 || out_valid !== 1'b1 || {out_regw, out_memw, out_memr} !== 3'b0) begin
            n_fail++;
            $display("FAIL brn_not_taken: flush=%b valid=%b ctl=%b%b%b expected 0/1/000",
                     out_flush, out_valid, out_regw, out_memw, out_memr);
        end
        drive_alu(3'b000, 32'd0, 32'd0);
        in_memr = 1;
        step();
        n_checks++;
        if (out_z !== 1'b0 || out_memr !== 1'b1 || out_regw !== 1'b1) begin
            n_fail++;
            $display("FAIL load_flags: z=%b memr=%b regw=%b expected 0/1/1", out_z, out_memr, out_regw);
        end
    endtask

    task automatic test_stall();
        drive_alu(3'b000, 32'd10, 32'd20);
        step();
        idle(); in_valid = 1; in_j = 1; in_rd1 = 32'h200; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_flush !== 1'b0 || out_alu !== 32'd30 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: flush=%b alu=%0d valid=%b expected 0/30/1", i, out_flush, out_alu, out_valid);
            end
        end
        mem_stall = 0;
        step();
        n_checks++;
        if (out_flush !== 1'b1 || out_target !== 32'h200) begin
            n_fail++; $display("FAIL stall_release: flush=%b target=%h expected 1/200", out_flush, out_target);
        end
        idle();
        step();
        n_checks++;
        if (out_flush !== 1'b0) begin
            n_fail++; $display("FAIL flush_once: flush=%b expected 0", out_flush);
        end
    endtask

    task automatic test_wai();
        drive_alu(3'b001, 32'd3, 32'd5);
        step();
        drive_alu(3'b001, 32'd3, 32'd3);
        in_wai = 1; in_PC = 32'h100;
        step();
        n_checks++;
        if (out_alu !== 32'h100 || out_z !== 1'b0 || out_n !== 1'b1) begin
            n_fail++;
            $display("FAIL wai: alu=%h z=%b n=%b expected 100/0/1", out_alu, out_z, out_n);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_flags_brz();
        test_brn_not_taken();
        test_stall();
        test_wai();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
